viterbi_ctrl: RTL and testbench

- Frame sequencer for the 4-state (K=3, rate-1/2) hard-decision Viterbi decoder.
- Owns the path-metric registers that feed the ACS unit, steps the trellis once per accepted symbol, normalises metrics, and stores the 4 decision bits per step in an internal survivor memory.
- At frame end, traces back from S0 (trellis terminated by tail bits) and streams the decoded data bits in forward order over a valid/ready interface.

---
 rtl/viterbi_ctrl_if.sv | 46 ++++
 rtl/viterbi_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_viterbi_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/viterbi_ctrl_if.sv
// Bus between the Viterbi frame sequencer and its neighbours (BMU/ACS on
// the input side, the bit sink on the output side).
//
// Handshake rule for both streams: a transfer happens on a rising clock
// edge where valid and ready are both high.  The symbol stream uses
// sym_valid_i/sym_ready_o and the output bit stream uses
// bit_valid_o/bit_ready_i.  The sender holds its payload stable while
// valid is high and ready is low.
interface viterbi_ctrl_if;
    logic       start_i;
    logic       sym_valid_i;
    logic       sym_ready_o;
    logic [3:0] dec_bits_i;
    logic [7:0] pm_new_s0_i;
    logic [7:0] pm_new_s1_i;
    logic [7:0] pm_new_s2_i;
    logic [7:0] pm_new_s3_i;
    logic [7:0] pm_s0_o;
    logic [7:0] pm_s1_o;
    logic [7:0] pm_s2_o;
    logic [7:0] pm_s3_o;
    logic       bit_o;
    logic       bit_valid_o;
    logic       bit_ready_i;
    logic       busy_o;
    logic       frame_done_o;
    logic [2:0] state_dbg;

    // Environment side: drives symbols/decisions, consumes bits.
    modport master (
        output start_i, sym_valid_i, dec_bits_i,
               pm_new_s0_i, pm_new_s1_i, pm_new_s2_i, pm_new_s3_i,
               bit_ready_i,
        input  sym_ready_o, pm_s0_o, pm_s1_o, pm_s2_o, pm_s3_o,
               bit_o, bit_valid_o, busy_o, frame_done_o, state_dbg
    );

    // Controller side.
    modport slave (
        input  start_i, sym_valid_i, dec_bits_i,
               pm_new_s0_i, pm_new_s1_i, pm_new_s2_i, pm_new_s3_i,
               bit_ready_i,
        output sym_ready_o, pm_s0_o, pm_s1_o, pm_s2_o, pm_s3_o,
               bit_o, bit_valid_o, busy_o, frame_done_o, state_dbg
    );
endinterface

// File: rtl/viterbi_ctrl.sv
// Frame sequencer for a 4-state (K=3, rate-1/2) hard-decision Viterbi
// decoder.  Holds the path metrics fed to the ACS, records one 4-bit
// decision word per trellis step, traces back from S0 at frame end and
// streams the decoded data bits out in forward order.
//
// Trellis convention: ns = {u, p[1]}; predecessors of ns are {ns[0],0}
// and {ns[0],1}; decision bit n = 1 selects the odd predecessor.
module viterbi_ctrl #(
    parameter int FRAME_LEN   = 34,
    parameter int TAIL_LEN    = 2,
    parameter int PM_INIT     = 32,
    parameter int NORM_THRESH = 128
) (
    input  logic          clk_i,
    input  logic          rst_i,
    viterbi_ctrl_if.slave bus
);

    localparam int AW    = $clog2(FRAME_LEN);
    localparam int NDATA = FRAME_LEN - TAIL_LEN;

    localparam logic [AW-1:0] LAST_STEP = AW'(FRAME_LEN - 1);
    localparam logic [AW-1:0] LAST_BIT  = AW'(NDATA - 1);
    localparam logic [7:0]    PM_START  = 8'(PM_INIT);
    localparam logic [7:0]    THRESH    = 8'(NORM_THRESH);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ACS  = 3'd1,
        S_TB   = 3'd2,
        S_OUT  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [AW-1:0] step_cnt;
    logic [AW-1:0] tb_idx;
    logic [AW-1:0] out_idx;
    logic [1:0]    tb_state;
    logic          tb_dec;

    // Survivor memory and decoded-bit buffer: plain storage, never reset.
    logic [3:0] mem    [FRAME_LEN];
    logic       bitbuf [FRAME_LEN];

    logic [7:0] pm     [4];
    logic [7:0] pm_new [4];
    logic [7:0] min01;
    logic [7:0] min23;
    logic [7:0] pm_min;
    logic       norm;

    logic sym_ready;
    logic bit_valid;
    logic busy;
    logic frame_done;
    logic step_acc;
    logic bit_acc;

    assign pm_new[0] = bus.pm_new_s0_i;
    assign pm_new[1] = bus.pm_new_s1_i;
    assign pm_new[2] = bus.pm_new_s2_i;
    assign pm_new[3] = bus.pm_new_s3_i;

    assign step_acc = bus.sym_valid_i & sym_ready;
    assign bit_acc  = bit_valid & bus.bit_ready_i;

    // Decision bit of the current traceback state at the current index.
    assign tb_dec = mem[tb_idx][tb_state];

    // Smallest incoming metric decides whether the whole set is rebased.
    always_comb begin
        min01  = (pm_new[0] < pm_new[1]) ? pm_new[0] : pm_new[1];
        min23  = (pm_new[2] < pm_new[3]) ? pm_new[2] : pm_new[3];
        pm_min = (min01 < min23) ? min01 : min23;
        norm   = (pm_min >= THRESH);
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_nxt  = state;
        sym_ready  = 1'b0;
        bit_valid  = 1'b0;
        busy       = 1'b1;
        frame_done = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (bus.start_i) begin
                    state_nxt = S_ACS;
                end
            end
            S_ACS: begin
                sym_ready = 1'b1;
                if (bus.sym_valid_i && (step_cnt == LAST_STEP)) begin
                    state_nxt = S_TB;
                end
            end
            S_TB: begin
                if (tb_idx == '0) begin
                    state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                bit_valid = 1'b1;
                if (bus.bit_ready_i && (out_idx == LAST_BIT)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                frame_done = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Metrics, step counter and traceback/output pointers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int n = 0; n < 4; n++) begin
                pm[n] <= 8'd0;
            end
            step_cnt <= '0;
            tb_idx   <= '0;
            tb_state <= 2'b00;
            out_idx  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        pm[0]    <= 8'd0;
                        pm[1]    <= PM_START;
                        pm[2]    <= PM_START;
                        pm[3]    <= PM_START;
                        step_cnt <= '0;
                    end
                end
                S_ACS: begin
                    if (step_acc) begin
                        for (int n = 0; n < 4; n++) begin
                            pm[n] <= norm ? (pm_new[n] - THRESH) : pm_new[n];
                        end
                        step_cnt <= step_cnt + 1'b1;
                        if (step_cnt == LAST_STEP) begin
                            tb_state <= 2'b00;
                            tb_idx   <= LAST_STEP;
                            out_idx  <= '0;
                        end
                    end
                end
                S_TB: begin
                    tb_state <= {tb_state[0], tb_dec};
                    tb_idx   <= tb_idx - 1'b1;
                end
                S_OUT: begin
                    if (bit_acc) begin
                        out_idx <= out_idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Decision capture during ACS and decoded-bit capture during traceback.
    always_ff @(posedge clk_i) begin
        if ((state == S_ACS) && step_acc) begin
            mem[step_cnt] <= bus.dec_bits_i;
        end
        if (state == S_TB) begin
            bitbuf[tb_idx] <= tb_state[1];
        end
    end

    assign bus.sym_ready_o  = sym_ready;
    assign bus.bit_valid_o  = bit_valid;
    assign bus.bit_o        = bit_valid ? bitbuf[out_idx] : 1'b0;
    assign bus.busy_o       = busy;
    assign bus.frame_done_o = frame_done;
    assign bus.pm_s0_o      = pm[0];
    assign bus.pm_s1_o      = pm[1];
    assign bus.pm_s2_o      = pm[2];
    assign bus.pm_s3_o      = pm[3];
    assign bus.state_dbg    = state;

endmodule

// File: tb/tb_viterbi_ctrl.sv
// Bench for viterbi_ctrl: two instances (34-step and 6-step frames) share
// one set of stimulus signals; sel chooses which one is started and
// observed.  A behavioural encoder + ACS model produces the metrics and
// decisions fed to the controller and the metrics expected back.
module tb_viterbi_ctrl;

  localparam int FL_A = 34;
  localparam int FL_B = 6;
  localparam int TAIL = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // shared stimulus
  logic       sel;
  logic       start;
  logic       sym_valid;
  logic       bit_ready;
  logic [3:0] dec;
  logic [7:0] pmn [4];

  viterbi_ctrl_if if_a ();
  viterbi_ctrl_if if_b ();

  viterbi_ctrl #(.FRAME_LEN(FL_A), .TAIL_LEN(TAIL), .PM_INIT(32), .NORM_THRESH(128))
    u_dut_a (.clk_i(clk), .rst_i(rst), .bus(if_a.slave));
  viterbi_ctrl #(.FRAME_LEN(FL_B), .TAIL_LEN(TAIL), .PM_INIT(32), .NORM_THRESH(128))
    u_dut_b (.clk_i(clk), .rst_i(rst), .bus(if_b.slave));

  assign if_a.start_i     = start & ~sel;
  assign if_b.start_i     = start & sel;
  assign if_a.sym_valid_i = sym_valid;
  assign if_b.sym_valid_i = sym_valid;
  assign if_a.dec_bits_i  = dec;
  assign if_b.dec_bits_i  = dec;
  assign if_a.pm_new_s0_i = pmn[0];
  assign if_a.pm_new_s1_i = pmn[1];
  assign if_a.pm_new_s2_i = pmn[2];
  assign if_a.pm_new_s3_i = pmn[3];
  assign if_b.pm_new_s0_i = pmn[0];
  assign if_b.pm_new_s1_i = pmn[1];
  assign if_b.pm_new_s2_i = pmn[2];
  assign if_b.pm_new_s3_i = pmn[3];
  assign if_a.bit_ready_i = bit_ready;
  assign if_b.bit_ready_i = bit_ready;

  // observed (selected) outputs
  logic        o_ready, o_valid, o_bit, o_busy, o_done;
  logic [31:0] o_pm;
  assign o_ready = sel ? if_b.sym_ready_o  : if_a.sym_ready_o;
  assign o_valid = sel ? if_b.bit_valid_o  : if_a.bit_valid_o;
  assign o_bit   = sel ? if_b.bit_o        : if_a.bit_o;
  assign o_busy  = sel ? if_b.busy_o       : if_a.busy_o;
  assign o_done  = sel ? if_b.frame_done_o : if_a.frame_done_o;
  assign o_pm    = sel ? {if_b.pm_s3_o, if_b.pm_s2_o, if_b.pm_s1_o, if_b.pm_s0_o}
                       : {if_a.pm_s3_o, if_a.pm_s2_o, if_a.pm_s1_o, if_a.pm_s0_o};

  // event counters
  int hs_cnt   = 0;
  int done_cnt = 0;
  always @(posedge clk) begin
    if (o_ready && sym_valid) hs_cnt <= hs_cnt + 1;
    if (o_done) done_cnt <= done_cnt + 1;
  end

  // scoreboard
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [35:0] step_q[$];   // {dec, pm_new3..0} per step
  logic [31:0] pm_q[$];     // expected registered metrics after each step
  logic [0:0]  exp_q[$];    // expected decoded bits in order

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // branch metric of edge p -> ns for received pair r (generators 7,5)
  function automatic int bm(input logic [1:0] p, input logic [1:0] ns,
                            input logic [1:0] r, input bit zero_bm);
    logic [1:0] c;
    c = {ns[1] ^ p[1] ^ p[0], ns[1] ^ p[0]};
    if (zero_bm) return (p == 2'd0 && ns == 2'd0) ? 0 : 2;
    return $countones(c ^ r);
  endfunction

  // encode data, run the model ACS, fill step_q / pm_q / exp_q
  task automatic build_frame(input int flen, input logic [255:0] data,
                             input int err_step, input bit zero_bm);
    int         pm [4];
    int         nw [4];
    int         me, mo, mn;
    logic [1:0] s, r, nsb, pe, po;
    logic [3:0] d;
    logic       u;
    step_q.delete(); pm_q.delete(); exp_q.delete();
    pm = '{0, 32, 32, 32};
    s = 2'b00;
    for (int k = 0; k < flen; k++) begin
      u = (k < flen - TAIL) ? data[k] : 1'b0;
      r = {u ^ s[1] ^ s[0], u ^ s[0]} ^ ((k == err_step) ? 2'b10 : 2'b00);
      s = {u, s[1]};
      for (int ns = 0; ns < 4; ns++) begin
        nsb = 2'(ns);
        pe = {nsb[0], 1'b0};
        po = {nsb[0], 1'b1};
        me = pm[pe] + bm(pe, nsb, r, zero_bm);
        mo = pm[po] + bm(po, nsb, r, zero_bm);
        d[ns]  = (mo < me);
        nw[ns] = (mo < me) ? mo : me;
      end
      step_q.push_back({d, 8'(nw[3]), 8'(nw[2]), 8'(nw[1]), 8'(nw[0])});
      mn = nw[0];
      for (int n = 1; n < 4; n++) if (nw[n] < mn) mn = nw[n];
      for (int n = 0; n < 4; n++) pm[n] = (mn >= 128) ? nw[n] - 128 : nw[n];
      pm_q.push_back({8'(pm[3]), 8'(pm[2]), 8'(pm[1]), 8'(pm[0])});
    end
    for (int k = 0; k < flen - TAIL; k++) exp_q.push_back(data[k]);
  endtask

  // drive one full frame from the queues and check everything observable
  task automatic run_frame(input int flen, input bit gaps, input bit bp, input bit poke);
    int   h0, d0, lat, got, cyc;
    logic prev_stall, prev_bit;
    h0 = hs_cnt;
    d0 = done_cnt;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("busy_after_start", 64'(o_busy), 64'd1);
    for (int k = 0; k < flen; k++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        sym_valid = 1'b0;
        dec = 4'($urandom);
        for (int n = 0; n < 4; n++) pmn[n] = 8'($urandom);
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      {dec, pmn[3], pmn[2], pmn[1], pmn[0]} = step_q[k];
      sym_valid = 1'b1;
      chk("sym_ready", 64'(o_ready), 64'd1);
      @(negedge clk);
      chk("pm_step", 64'(o_pm), 64'(pm_q[k]));
    end
    sym_valid = 1'b0;
    chk("ready_drop", 64'(o_ready), 64'd0);
    lat = 1;
    while (!o_valid && lat < flen + 10) begin
      start = poke && (lat == 2);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk("latency", 64'(lat), 64'(flen + 1));
    got = 0;
    cyc = 0;
    prev_stall = 1'b0;
    prev_bit = 1'b0;
    while (got < flen - TAIL && cyc < 2000) begin
      if (prev_stall) chk("stall_hold", 64'({o_valid, o_bit}), 64'({1'b1, prev_bit}));
      bit_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      start = poke && (cyc == 1);
      if (o_valid && bit_ready) begin
        chk("bit", 64'(o_bit), 64'(exp_q.pop_front()));
        got++;
      end
      prev_stall = o_valid && !bit_ready;
      prev_bit = o_bit;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    bit_ready = 1'b0;
    chk("bit_count", 64'(got), 64'(flen - TAIL));
    chk("done_cycle", 64'({o_done, o_valid}), 64'(2'b10));
    @(negedge clk);
    chk("idle_after_done", 64'({o_done, o_busy}), 64'd0);
    chk("handshakes", 64'(hs_cnt - h0), 64'(flen));
    chk("done_pulses", 64'(done_cnt - d0), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] data;
    sel = 1'b0; start = 1'b0; sym_valid = 1'b0; bit_ready = 1'b0; dec = 4'd0;
    for (int n = 0; n < 4; n++) pmn[n] = 8'd0;

    // reset state of both instances
    repeat (3) @(negedge clk);
    chk("reset_a", 64'({o_ready, o_valid, o_busy, o_done, o_bit, o_pm}), 64'd0);
    sel = 1'b1;
    #1;
    chk("reset_b", 64'({o_ready, o_valid, o_busy, o_done, o_bit, o_pm}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // all-zero frame, 34 steps, S0->S0 free and every other branch costs 2
    sel = 1'b0;
    build_frame(FL_A, 256'd0, -1, 1'b1);
    run_frame(FL_A, 1'b0, 1'b0, 1'b0);
    chk("zero_pm_s0_end", 64'(o_pm[7:0]), 64'd0);

    // known sequence 1,0,1,1 + 00 tail, error-free, start poked in TB/OUT
    sel = 1'b1;
    data = 256'b1101;
    build_frame(FL_B, data, -1, 1'b0);
    run_frame(FL_B, 1'b0, 1'b0, 1'b1);
    chk("known_pm_s0_end", 64'(o_pm[7:0]), 64'd0);

    // same sequence with one channel bit flipped
    build_frame(FL_B, data, 2, 1'b0);
    run_frame(FL_B, 1'b0, 1'b1, 1'b0);

    // normalisation: rebased set, then pass-through set
    step_q.delete(); pm_q.delete(); exp_q.delete();
    step_q.push_back({4'd0, 8'd129, 8'd140, 8'd131, 8'd130});
    pm_q.push_back({8'd1, 8'd12, 8'd3, 8'd2});
    step_q.push_back({4'd0, 8'd200, 8'd200, 8'd200, 8'd127});
    pm_q.push_back({8'd200, 8'd200, 8'd200, 8'd127});
    for (int k = 2; k < FL_B; k++) begin
      step_q.push_back(36'd0);
      pm_q.push_back(32'd0);
    end
    for (int k = 0; k < FL_B - TAIL; k++) exp_q.push_back(1'b0);
    run_frame(FL_B, 1'b0, 1'b0, 1'b0);

    // random data frames with symbol gaps, backpressure and start pokes
    sel = 1'b0;
    for (int f = 0; f < 3; f++) begin
      data = 256'($urandom);
      build_frame(FL_A, data, (f == 2) ? int'($urandom_range(0, FL_A - 1)) : -1, 1'b0);
      run_frame(FL_A, 1'b1, 1'b1, 1'b1);
    end

    // reset after 10 accepted steps, then a clean frame
    data = 256'($urandom);
    build_frame(FL_A, data, -1, 1'b0);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      {dec, pmn[3], pmn[2], pmn[1], pmn[0]} = step_q[k];
      sym_valid = 1'b1;
      @(negedge clk);
    end
    sym_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("reset_mid", 64'({o_ready, o_valid, o_busy, o_done, o_bit, o_pm}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", 64'({o_busy, o_valid}), 64'd0);
    data = 256'($urandom);
    build_frame(FL_A, data, -1, 1'b0);
    run_frame(FL_A, 1'b1, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
